// File: rtl/d_miss_queue.sv
// rtl/d_miss_queue.sv - non-blocking D_cache miss queue with duplicate merge and in-order L2 issue/fill
module d_miss_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       miss_valid,
    input  logic [ADDR_W-1:0]          miss_address,
    output logic                       miss_ready,
    output logic                       l2_req_valid,
    output logic [ADDR_W-1:0]          l2_req_address,
    input  logic                       l2_req_ready,
    input  logic                       l2_resp_valid,
    input  logic [DATA_W-1:0]          l2_resp_data,
    output logic [DATA_W-1:0]          cache_in,
    output logic [ADDR_W-1:0]          cache_address,
    output logic                       cache_in_start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       resp_error
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_FREE, S_PEND, S_WAIT} state_t;

    state_t            r_state [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [PW-1:0]     r_alloc_ptr;
    logic [PW-1:0]     r_issue_ptr;
    logic [PW-1:0]     r_retire_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_cache_in;
    logic [ADDR_W-1:0] r_cache_address;
    logic              r_cache_in_start;
    logic              r_resp_error;

    logic w_hit;
    logic w_alloc;
    logic w_issue;
    logic w_retire;

    // A retiring entry still counts as a hit this cycle, so its duplicate is merged rather than re-fetched.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] != S_FREE && r_addr[i] == miss_address) begin
                w_hit = 1'b1;
            end
        end
    end

    assign miss_ready     = (r_count < CW'(DEPTH));
    assign w_alloc        = miss_valid && miss_ready && !w_hit;
    assign l2_req_valid   = (r_state[r_issue_ptr] == S_PEND);
    assign l2_req_address = r_addr[r_issue_ptr];
    assign w_issue        = l2_req_valid && l2_req_ready;
    assign w_retire       = l2_resp_valid && (r_state[r_retire_ptr] == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_FREE;
            end
            r_alloc_ptr      <= '0;
            r_issue_ptr      <= '0;
            r_retire_ptr     <= '0;
            r_count          <= '0;
            r_cache_in       <= '0;
            r_cache_address  <= '0;
            r_cache_in_start <= 1'b0;
            r_resp_error     <= 1'b0;
        end else begin
            // alloc, issue and retire always touch distinct entries, so their updates never collide
            if (w_alloc) begin
                r_state[r_alloc_ptr] <= S_PEND;
                r_alloc_ptr          <= r_alloc_ptr + PW'(1);
            end
            if (w_issue) begin
                r_state[r_issue_ptr] <= S_WAIT;
                r_issue_ptr          <= r_issue_ptr + PW'(1);
            end
            if (w_retire) begin
                r_state[r_retire_ptr] <= S_FREE;
                r_retire_ptr          <= r_retire_ptr + PW'(1);
                r_cache_in            <= l2_resp_data;
                r_cache_address       <= r_addr[r_retire_ptr];
            end
            r_count          <= r_count + CW'(w_alloc) - CW'(w_retire);
            r_cache_in_start <= w_retire;
            if (l2_resp_valid && !w_retire) begin
                r_resp_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_alloc_ptr] <= miss_address;
        end
    end

    assign count          = r_count;
    assign cache_in       = r_cache_in;
    assign cache_address  = r_cache_address;
    assign cache_in_start = r_cache_in_start;
    assign resp_error     = r_resp_error;
endmodule

// File: tb/tb_d_miss_queue.sv
// tb/tb_d_miss_queue.sv - directed self-checking bench for d_miss_queue
module tb_d_miss_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic [63:0] miss_address;
    logic        miss_ready;
    logic        l2_req_valid;
    logic [63:0] l2_req_address;
    logic        l2_req_ready;
    logic        l2_resp_valid;
    logic [63:0] l2_resp_data;
    logic [63:0] cache_in;
    logic [63:0] cache_address;
    logic        cache_in_start;
    logic [2:0]  count;
    logic        resp_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] fill_addr_q[$];
    logic [63:0] fill_data_q[$];
    logic [63:0] req_q[$];

    d_miss_queue #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_address(miss_address), .miss_ready(miss_ready),
        .l2_req_valid(l2_req_valid), .l2_req_address(l2_req_address), .l2_req_ready(l2_req_ready),
        .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
        .cache_in(cache_in), .cache_address(cache_address), .cache_in_start(cache_in_start),
        .count(count), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    // Records every fill pulse and every accepted L2 request, sampled mid-cycle.
    always @(negedge clk) begin
        if (cache_in_start) begin
            fill_addr_q.push_back(cache_address);
            fill_data_q.push_back(cache_in);
        end
        if (l2_req_valid && l2_req_ready) begin
            req_q.push_back(l2_req_address);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        fill_addr_q.delete();
        fill_data_q.delete();
        req_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; miss_valid = 1'b0; miss_address = '0; l2_req_ready = 1'b0;
        l2_resp_valid = 1'b0; l2_resp_data = '0;
        cyc(); cyc();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_miss_ready: got %b expected 1", miss_ready); end
        n_cmp++; if (l2_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_l2_req_valid: got %b expected 0", l2_req_valid); end
        n_cmp++; if (cache_in_start !== 1'b0) begin n_err++; $display("FAIL reset_cache_in_start: got %b expected 0", cache_in_start); end
        n_cmp++; if (cache_in !== 64'h0) begin n_err++; $display("FAIL reset_cache_in: got %h expected 0", cache_in); end
        n_cmp++; if (cache_address !== 64'h0) begin n_err++; $display("FAIL reset_cache_address: got %h expected 0", cache_address); end
        n_cmp++; if (resp_error !== 1'b0) begin n_err++; $display("FAIL reset_resp_error: got %b expected 0", resp_error); end
        cyc(); cyc();
        n_cmp++; if (count !== 3'd0 || miss_ready !== 1'b1 || l2_req_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_state: count %0d ready %b req %b expected 0 1 0", count, miss_ready, l2_req_valid);
        end
    endtask

    task automatic test_single();
        clear_logs();
        l2_req_ready = 1'b1;
        miss_valid = 1'b1; miss_address = 64'h1000;
        cyc();
        miss_valid = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_alloc: got %0d expected 1", count); end
        n_cmp++; if (l2_req_valid !== 1'b1 || l2_req_address !== 64'h1000) begin
            n_err++; $display("FAIL single_req: valid %b addr %h expected 1 1000", l2_req_valid, l2_req_address);
        end
        cyc();
        n_cmp++; if (l2_req_valid !== 1'b0) begin n_err++; $display("FAIL single_req_after_issue: got %b expected 0", l2_req_valid); end
        cyc(); cyc();
        l2_resp_valid = 1'b1; l2_resp_data = 64'hDEAD_BEEF;
        cyc();
        l2_resp_valid = 1'b0; l2_resp_data = '0;
        n_cmp++; if (cache_in_start !== 1'b1) begin n_err++; $display("FAIL single_pulse: got %b expected 1", cache_in_start); end
        n_cmp++; if (cache_in !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_cache_in: got %h expected deadbeef", cache_in); end
        n_cmp++; if (cache_address !== 64'h1000) begin n_err++; $display("FAIL single_cache_address: got %h expected 1000", cache_address); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_end: got %0d expected 0", count); end
        cyc();
        n_cmp++; if (cache_in_start !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b expected 0", cache_in_start); end
        n_cmp++; if (cache_in !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_cache_in_hold: got %h expected deadbeef", cache_in); end
        n_cmp++; if (fill_addr_q.size() != 1) begin n_err++; $display("FAIL single_fill_count: got %0d expected 1", fill_addr_q.size()); end
    endtask

    task automatic test_merge();
        logic [63:0] addrs[3];
        int peak;
        addrs[0] = 64'h1000; addrs[1] = 64'h1000; addrs[2] = 64'h2000;
        clear_logs();
        peak = 0;
        l2_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            miss_valid = 1'b1; miss_address = addrs[i];
            cyc();
            if (int'(count) > peak) peak = int'(count);
        end
        miss_valid = 1'b0;
        cyc();
        l2_resp_valid = 1'b1; l2_resp_data = 64'hA1;
        cyc();
        l2_resp_data = 64'hA2;
        cyc();
        l2_resp_valid = 1'b0;
        cyc(); cyc();
        n_cmp++; if (peak != 2) begin n_err++; $display("FAIL merge_peak_count: got %0d expected 2", peak); end
        n_cmp++; if (req_q.size() != 2) begin n_err++; $display("FAIL merge_req_count: got %0d expected 2", req_q.size()); end
        else begin
            n_cmp++; if (req_q[0] !== 64'h1000 || req_q[1] !== 64'h2000) begin
                n_err++; $display("FAIL merge_req_order: got %h %h expected 1000 2000", req_q[0], req_q[1]);
            end
        end
        n_cmp++; if (fill_addr_q.size() != 2) begin n_err++; $display("FAIL merge_fill_count: got %0d expected 2", fill_addr_q.size()); end
        else begin
            n_cmp++; if (fill_addr_q[0] !== 64'h1000 || fill_addr_q[1] !== 64'h2000) begin
                n_err++; $display("FAIL merge_fill_addr: got %h %h expected 1000 2000", fill_addr_q[0], fill_addr_q[1]);
            end
            n_cmp++; if (fill_data_q[0] !== 64'hA1 || fill_data_q[1] !== 64'hA2) begin
                n_err++; $display("FAIL merge_fill_data: got %h %h expected a1 a2", fill_data_q[0], fill_data_q[1]);
            end
        end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL merge_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_full();
        clear_logs();
        l2_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_address = 64'h10 * 64'(i + 1);
            cyc();
        end
        miss_valid = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", count); end
        n_cmp++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL full_miss_ready: got %b expected 0", miss_ready); end
        n_cmp++; if (l2_req_valid !== 1'b1 || l2_req_address !== 64'h10) begin
            n_err++; $display("FAIL full_req_head: valid %b addr %h expected 1 10", l2_req_valid, l2_req_address);
        end
        miss_valid = 1'b1; miss_address = 64'h50;
        cyc();
        miss_valid = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_fifth_rejected: count %0d expected 4", count); end
        n_cmp++; if (l2_req_address !== 64'h10) begin n_err++; $display("FAIL full_req_stable: got %h expected 10", l2_req_address); end
        l2_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        l2_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            l2_resp_valid = 1'b1; l2_resp_data = 64'hF0 + 64'(i);
            cyc();
        end
        l2_resp_valid = 1'b0;
        cyc(); cyc();
        n_cmp++; if (req_q.size() != 4) begin n_err++; $display("FAIL full_req_count: got %0d expected 4", req_q.size()); end
        n_cmp++; if (fill_addr_q.size() != 4) begin n_err++; $display("FAIL full_fill_count: got %0d expected 4", fill_addr_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (fill_addr_q[i] !== 64'h10 * 64'(i + 1) || fill_data_q[i] !== 64'hF0 + 64'(i)) begin
                    n_err++; $display("FAIL full_fill_%0d: addr %h data %h expected %h %h", i, fill_addr_q[i],
                                      fill_data_q[i], 64'h10 * 64'(i + 1), 64'hF0 + 64'(i));
                end
            end
        end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL full_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_resp_error();
        clear_logs();
        n_cmp++; if (resp_error !== 1'b0) begin n_err++; $display("FAIL err_before: got %b expected 0", resp_error); end
        l2_resp_valid = 1'b1; l2_resp_data = 64'h5555;
        cyc();
        l2_resp_valid = 1'b0;
        n_cmp++; if (cache_in_start !== 1'b0) begin n_err++; $display("FAIL err_no_fill: got %b expected 0", cache_in_start); end
        n_cmp++; if (resp_error !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", resp_error); end
        cyc(); cyc(); cyc();
        n_cmp++; if (resp_error !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", resp_error); end
        n_cmp++; if (fill_addr_q.size() != 0) begin n_err++; $display("FAIL err_fill_count: got %0d expected 0", fill_addr_q.size()); end
    endtask

    task automatic test_stream();
        int sent;
        int rsp;
        int c;
        clear_logs();
        sent = 0; rsp = 0;
        l2_req_ready = 1'b1;
        for (c = 0; c < 200 && fill_addr_q.size() < 12; c++) begin
            miss_valid   = (sent < 12);
            miss_address = 64'h1_0000 + 64'(sent) * 64'h40;
            l2_resp_valid = (rsp < req_q.size());
            if (l2_resp_valid) l2_resp_data = req_q[rsp] + 64'h5A5A;
            else               l2_resp_data = '0;
            @(negedge clk);
            if (miss_valid && miss_ready) sent++;
            if (l2_resp_valid) rsp++;
            cyc();
        end
        miss_valid = 1'b0; l2_resp_valid = 1'b0; l2_req_ready = 1'b0;
        cyc(); cyc();
        n_cmp++; if (fill_addr_q.size() != 12) begin n_err++; $display("FAIL stream_fill_count: got %0d expected 12", fill_addr_q.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++; if (fill_addr_q[i] !== 64'h1_0000 + 64'(i) * 64'h40) begin
                    n_err++; $display("FAIL stream_addr_%0d: got %h expected %h", i, fill_addr_q[i], 64'h1_0000 + 64'(i) * 64'h40);
                end
                n_cmp++; if (fill_data_q[i] !== 64'h1_0000 + 64'(i) * 64'h40 + 64'h5A5A) begin
                    n_err++; $display("FAIL stream_data_%0d: got %h expected %h", i, fill_data_q[i], 64'h1_0000 + 64'(i) * 64'h40 + 64'h5A5A);
                end
            end
        end
        n_cmp++; if (req_q.size() != 12) begin n_err++; $display("FAIL stream_req_count: got %0d expected 12", req_q.size()); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        l2_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            miss_valid = 1'b1; miss_address = 64'h7000 + 64'(i) * 64'h100;
            cyc();
        end
        miss_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL midrst_count_before: got %0d expected 3", count); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count); end
        n_cmp++; if (l2_req_valid !== 1'b0 || miss_ready !== 1'b1 || resp_error !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: req %b ready %b err %b expected 0 1 0", l2_req_valid, miss_ready, resp_error);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_merge();
        test_full();
        test_resp_error();
        test_stream();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
